// File: rtl/exc_ctrl_if.sv
// Exception-commit bundle between the MEM stage / CP0 and exc_ctrl.
// slave: the exception controller; master: the pipeline/CP0 side.
interface exc_ctrl_if;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [8:0]  mem_exc_i;
  logic [31:0] mem_addr_i;
  logic        stall_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        timer_int_i;

  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic        newpc_valid_o;
  logic        busy_o;

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_exc_i, mem_addr_i,
           stall_i, cp0_status_i, cp0_cause_i, cp0_epc_i, timer_int_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
           flush_o, newpc_o, newpc_valid_o, busy_o
  );

  modport master (
    output mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_exc_i, mem_addr_i,
           stall_i, cp0_status_i, cp0_cause_i, cp0_epc_i, timer_int_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
           flush_o, newpc_o, newpc_valid_o, busy_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception initiator: prioritises MEM-stage exceptions and interrupts, commits to CP0,
// then flushes and redirects. Optional macro EXC_TIMER_INT_EN folds timer_int_i into IP7.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst,
  exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic        int_pend;
  logic [7:0]  ip_bits;
  logic        int_req;
  logic        accept;
  logic [31:0] exc_code;
  logic [31:0] exc_bad;

`ifdef EXC_TIMER_INT_EN
  assign ip_bits = bus.cp0_cause_i[15:8] | {bus.timer_int_i, 7'b0};
  logic unused_bits;
  assign unused_bits = ^{bus.cp0_status_i[31:16], bus.cp0_status_i[7:2],
                         bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0]};
`else
  assign ip_bits = bus.cp0_cause_i[15:8];
  logic unused_bits;
  assign unused_bits = ^{bus.cp0_status_i[31:16], bus.cp0_status_i[7:2],
                         bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0],
                         bus.timer_int_i};
`endif

  assign int_req = bus.cp0_status_i[0] & ~bus.cp0_status_i[1] &
                   (|(bus.cp0_status_i[15:8] & ip_bits));

  // The interrupt is seen through the registered int_pend, never int_req directly.
  assign accept = (state == IDLE) & bus.mem_valid_i & ~bus.stall_i &
                  (int_pend | (|bus.mem_exc_i));

  // NOTE: every variable gets a default first so the priority chain cannot infer a latch.
  always_comb begin
    exc_code = 32'h0;
    exc_bad  = 32'h0;
    if (int_pend)                 exc_code = 32'h1;
    else if (bus.mem_exc_i[0]) begin
      exc_code = 32'h4;
      exc_bad  = bus.mem_pc_i;
    end
    else if (bus.mem_exc_i[1])    exc_code = 32'ha;
    else if (bus.mem_exc_i[2])    exc_code = 32'h8;
    else if (bus.mem_exc_i[3])    exc_code = 32'h9;
    else if (bus.mem_exc_i[4])    exc_code = 32'hd;
    else if (bus.mem_exc_i[5])    exc_code = 32'hc;
    else if (bus.mem_exc_i[6]) begin
      exc_code = 32'h4;
      exc_bad  = bus.mem_addr_i;
    end
    else if (bus.mem_exc_i[7]) begin
      exc_code = 32'h5;
      exc_bad  = bus.mem_addr_i;
    end
    else if (bus.mem_exc_i[8])    exc_code = 32'he;
  end

  // NOTE: sequential state uses non-blocking assignments; the one-cycle commit fields are
  // defaulted to 0 each edge and only the accept branch overrides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      flush_cnt               <= 4'd0;
      int_pend                <= 1'b0;
      bus.excepttype_o        <= 32'h0;
      bus.current_inst_addr_o <= 32'h0;
      bus.is_in_delayslot_o   <= 1'b0;
      bus.bad_addr_o          <= 32'h0;
      bus.flush_o             <= 1'b0;
      bus.newpc_o             <= 32'h0;
      bus.newpc_valid_o       <= 1'b0;
      bus.busy_o              <= 1'b0;
    end else begin
      int_pend                <= int_req & ~(accept & int_pend);
      bus.excepttype_o        <= 32'h0;
      bus.current_inst_addr_o <= 32'h0;
      bus.is_in_delayslot_o   <= 1'b0;
      bus.bad_addr_o          <= 32'h0;
      bus.newpc_valid_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state                   <= FLUSH;
            flush_cnt               <= FLUSH_LAST;
            bus.flush_o             <= 1'b1;
            bus.busy_o              <= 1'b1;
            bus.excepttype_o        <= exc_code;
            bus.current_inst_addr_o <= bus.mem_pc_i;
            bus.is_in_delayslot_o   <= bus.mem_in_delayslot_i;
            bus.bad_addr_o          <= exc_bad;
            bus.newpc_o             <= (exc_code == 32'he) ? bus.cp0_epc_i : EXC_VECTOR;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state             <= REDIRECT;
            bus.newpc_valid_o <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        REDIRECT: begin
          state       <= IDLE;
          bus.flush_o <= 1'b0;
          bus.busy_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception initiator for the MIPS core. It sits between the MEM stage and the CP0 register file.
- Prioritises per-instruction exception flags and pending interrupts, then drives the CP0 exception-commit interface: type, PC, delay-slot flag and bad address.
- Sequences the pipeline flush and the PC redirect, to the exception vector or to EPC for ERET.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions except ERET.
- FLUSH_CYCLES, 2, number of cycles flush_o is held high (range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- mem_valid_i  in  1  MEM stage holds a real instruction (not a bubble).
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot.
- mem_exc_i  in  9  flags. [0] AdEL fetch, [1] RI, [2] syscall, [3] break, [4] trap, [5] Ov, [6] AdEL load, [7] AdES store, [8] ERET.
- mem_addr_i  in  32  load/store effective address.
- stall_i  in  1  MEM stage stalled this cycle.
- cp0_status_i  in  32  current CP0 Status.
- cp0_cause_i  in  32  current CP0 Cause.
- cp0_epc_i  in  32  current CP0 EPC.
- timer_int_i  in  1  CP0 timer interrupt (see optional feature).
- excepttype_o  out  32  to CP0. Codes: 0x1 Int, 0x4 AdEL, 0x5 AdES, 0x8 Sys, 0x9 Bp, 0xa RI, 0xc Ov, 0xd Tr, 0xe ERET, 0 none.
- current_inst_addr_o  out  32  to CP0: PC of the excepting instruction.
- is_in_delayslot_o  out  1  to CP0.
- bad_addr_o  out  32  to CP0: BadVAddr value.
- flush_o  out  1  flush IF..MEM.
- newpc_o  out  32  redirect target.
- newpc_valid_o  out  1  one-cycle redirect strobe.
- busy_o  out  1  FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, int_pend=0, flush counter=0. A reset in any state returns to IDLE at the next edge; a flush in progress is abandoned.
- Interrupt condition: int_req = status[0] & ~status[1] & |(status[15:8] & cause[15:8]).
- int_pend is a register. It is set when int_req=1, and cleared when int_req=0 or when the interrupt is taken.
- Accept condition, evaluated in IDLE: mem_valid_i & ~stall_i & (int_pend | |mem_exc_i). An interrupt only attaches to a valid, non-stalled instruction.
- Priority, highest first: Int, AdEL fetch, RI, Sys, Bp, Tr, Ov, AdEL load, AdES store, ERET. Exactly one code is produced per accepted instruction.
- Bad address: mem_pc_i for AdEL fetch; mem_addr_i for AdEL load and AdES store; 0 for all other codes.
- State IDLE to FLUSH on the accept edge. excepttype_o, current_inst_addr_o, is_in_delayslot_o and bad_addr_o are registered and valid for exactly one cycle, the first FLUSH cycle. They are 0 in every other cycle.
- FLUSH: flush_o=1 for FLUSH_CYCLES cycles.
- newpc_o is registered at accept time: EPC sampled from cp0_epc_i for ERET, EXC_VECTOR for everything else. It is held until the next accept.
- FLUSH to REDIRECT after FLUSH_CYCLES cycles. REDIRECT lasts one cycle: newpc_valid_o=1, flush_o=1. REDIRECT to IDLE.
- While busy_o=1, inputs are ignored, no new exception is accepted, and int_pend still tracks int_req.
- A new exception can be accepted in the first IDLE cycle after REDIRECT. Minimum spacing between accepts is FLUSH_CYCLES+2 cycles.
- ERET with a simultaneous int_pend is taken as Int; the ERET is not committed.
- Latency: accept edge to excepttype_o is 1 cycle; accept to newpc_valid_o is FLUSH_CYCLES+1 cycles.

Optional Feature:
- Macro EXC_TIMER_INT_EN.
- Defined: timer_int_i is ORed into cause bit 15 (IP7) before the interrupt check. Interrupts are taken when status[15]=1 even if cp0_cause_i[15]=0.
- Undefined: timer_int_i is unused, and only cp0_cause_i[15:8] is evaluated.

Test Plan:
- Syscall (mem_exc_i=9'h004) with pc=0xBFC00100, not in a delay slot -> 1 cycle later excepttype_o=0x8 and current_inst_addr_o=0xBFC00100; flush_o high for 2 cycles, then newpc_valid_o=1 with newpc_o=0xBFC00380.
- AdES (9'h080) with mem_addr_i=0x80000003 in a delay slot -> excepttype_o=0x5, bad_addr_o=0x80000003, is_in_delayslot_o=1.
- status=0x0000FF01 and cause=0x00000400 while mem_valid_i=0 for 3 cycles, then a valid non-stalled instruction at 0xBFC00200 -> no accept during the bubbles; then excepttype_o=0x1 and current_inst_addr_o=0xBFC00200.
- ERET (9'h100) with cp0_epc_i=0xBFC00404 -> excepttype_o=0xe, newpc_o=0xBFC00404. Same stimulus with stall_i=1 -> no response.
- RI and Ov set together (9'h022) -> excepttype_o=0xa only. A second syscall presented during FLUSH is ignored (busy_o=1).
- rst asserted in the second FLUSH cycle -> next cycle all outputs 0, busy_o=0, and newpc_valid_o is never pulsed.
